piece_pattern_decoder: RTL and testbench

- Inverse of the spawn-pattern lookup: takes a 2-row × 10-column occupancy pattern and recovers the 3-bit piece code and its column offset.
- Used by the game FSM after horizontal moves to re-identify the active piece from the board's top rows.
- Pattern is captured on a valid/ready handshake, then scanned one column per cycle. The result is held on a valid/ready output until consumed.

---
 rtl/piece_pkg.sv | 45 ++++
 rtl/piece_pattern_decoder_match.sv | 30 +++
 rtl/piece_pattern_decoder.sv | 180 ++++++++++++++++++
 tb/tb_piece_pattern_decoder.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/piece_pkg.sv
// -----------------------------------------------------------------------------
// piece_pkg
// Shared definitions for the piece spawn-pattern lookup and its inverse
// decoder.
//   ROW_W_DEF  : default number of board columns per row
//   WIN_W      : width of the piece bounding window (columns)
//   piece_t    : 3-bit piece code
//   PIECE_WIN  : {win0, win1} pattern per piece code, MSB = leftmost column
//   dec_state_t: decoder FSM states
// -----------------------------------------------------------------------------
package piece_pkg;

   localparam int ROW_W_DEF = 10;
   localparam int WIN_W     = 4;

   typedef enum logic [2:0] {
      PIECE_T = 3'd0,
      PIECE_J = 3'd1,
      PIECE_L = 3'd2,
      PIECE_S = 3'd3,
      PIECE_Z = 3'd4,
      PIECE_O = 3'd5,
      PIECE_I = 3'd6,
      PIECE_X = 3'd7
   } piece_t;

   // Entry n is the {row0, row1} window of piece code n.
   localparam logic [0:7][2*WIN_W-1:0] PIECE_WIN = {
      8'b0100_1110,
      8'b0010_1110,
      8'b1000_1110,
      8'b0110_1100,
      8'b1100_0110,
      8'b1100_1100,
      8'b0000_1111,
      8'b1110_1110
   };

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SCAN   = 2'd1,
      ST_RESULT = 2'd2
   } dec_state_t;

endpackage

// File: rtl/piece_pattern_decoder_match.sv
// -----------------------------------------------------------------------------
// piece_window_match
// Combinational lookup of a 2x4 occupancy window against the piece table.
//   win0, win1 : upper / lower row window bits, MSB = leftmost column
//   overflow   : occupancy seen to the right of the window
//   block      : matching piece code (0 when no match)
//   match      : 1 when the window is a legal piece and overflow is clear
// -----------------------------------------------------------------------------
module piece_window_match
   import piece_pkg::*;
(
   input  logic [WIN_W-1:0] win0,
   input  logic [WIN_W-1:0] win1,
   input  logic             overflow,
   output piece_t           block,
   output logic             match
);

   always_comb begin
      block = PIECE_T;
      match = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (!overflow && ({win0, win1} == PIECE_WIN[i])) begin
            block = piece_t'(3'(i));
            match = 1'b1;
         end
      end
   end

endmodule

// File: rtl/piece_pattern_decoder.sv
// -----------------------------------------------------------------------------
// piece_pattern_decoder
// Recovers piece code and column offset from a 2-row occupancy pattern.
// A pattern is captured on in_valid/in_ready, scanned one column per cycle
// (leftmost column first), and the result is held on out_valid/out_ready.
//   Clk, Reset_n : clock (rising edge), asynchronous active-low reset
//   in_valid     : row0/row1 carry a pattern
//   in_ready     : decoder idle, pattern will be accepted
//   row0, row1   : upper / lower row, column 0 at the MSB
//   out_valid    : result available
//   out_ready    : consumer takes the result
//   block        : decoded piece code (0 when match=0)
//   offset       : leftmost occupied column
//   match        : 1 when the pattern is a legal piece
//   err_count    : saturating count of consumed match=0 results
// Build option: define PIECE_DEC_ERRCNT_EN to instantiate the error counter;
// otherwise err_count is constant 0.
// -----------------------------------------------------------------------------
module piece_pattern_decoder
   import piece_pkg::*;
#(
   parameter int ROW_W = ROW_W_DEF,
   parameter int CNT_W = 8
)
(
   input  logic             Clk,
   input  logic             Reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [ROW_W-1:0] row0,
   input  logic [ROW_W-1:0] row1,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [2:0]       block,
   output logic [3:0]       offset,
   output logic             match,
   output logic [CNT_W-1:0] err_count
);

   dec_state_t       state_q;
   logic [3:0]       col_q;
   logic             found_q;
   logic             ovf_q;
   piece_t           block_q;
   logic [3:0]       offset_q;
   logic             match_q;

   logic [ROW_W-1:0] row0_q;
   logic [ROW_W-1:0] row1_q;
   logic [3:0]       off_q;
   logic [WIN_W-1:0] win0_q;
   logic [WIN_W-1:0] win1_q;

   logic             b0;
   logic             b1;
   logic             bit_any;
   logic [3:0]       rel;
   logic             in_win;
   logic [1:0]       wpos;
   logic             scan_active;
   logic             scan_done;
   piece_t           m_block;
   logic             m_match;

   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = (state_q == ST_RESULT);
   assign block     = block_q;
   assign offset    = offset_q;
   assign match     = match_q;

   // Capture registers shift left, so the current column is always the MSB.
   assign b0      = row0_q[ROW_W-1];
   assign b1      = row1_q[ROW_W-1];
   assign bit_any = b0 | b1;

   // Position relative to the latched offset; window slot 3-rel == ~rel[1:0].
   assign rel    = col_q - off_q;
   assign in_win = (rel < 4'd4);
   assign wpos   = ~rel[1:0];

   assign scan_active = (state_q == ST_SCAN) && (col_q != 4'(ROW_W));
   assign scan_done   = (state_q == ST_SCAN) && (col_q == 4'(ROW_W));

   piece_window_match u_match (
      .win0     (win0_q),
      .win1     (win1_q),
      .overflow (ovf_q),
      .block    (m_block),
      .match    (m_match)
   );

   // --- control: FSM, column counter, flags, result registers ---
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q  <= ST_IDLE;
         col_q    <= '0;
         found_q  <= 1'b0;
         ovf_q    <= 1'b0;
         block_q  <= PIECE_T;
         offset_q <= '0;
         match_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (in_valid) begin
                  state_q <= ST_SCAN;
                  col_q   <= '0;
                  found_q <= 1'b0;
                  ovf_q   <= 1'b0;
               end
            end
            ST_SCAN: begin
               if (scan_done) begin
                  // Window and overflow are final here; one extra cycle
                  // to register the lookup result.
                  block_q  <= m_block;
                  match_q  <= m_match;
                  offset_q <= off_q;
                  state_q  <= ST_RESULT;
               end else begin
                  col_q <= col_q + 4'd1;
                  if (bit_any) begin
                     if (!found_q) begin
                        found_q <= 1'b1;
                     end else if (!in_win) begin
                        ovf_q <= 1'b1;
                     end
                  end
               end
            end
            ST_RESULT: begin
               if (out_ready) begin
                  state_q <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // --- data: pattern capture and window assembly ---
   always_ff @(posedge Clk) begin
      if (in_valid && in_ready) begin
         row0_q <= row0;
         row1_q <= row1;
         off_q  <= '0;
         win0_q <= '0;
         win1_q <= '0;
      end else if (scan_active) begin
         row0_q <= row0_q << 1;
         row1_q <= row1_q << 1;
         if (!found_q && bit_any) begin
            off_q             <= col_q;
            win0_q[WIN_W-1]   <= b0;
            win1_q[WIN_W-1]   <= b1;
         end else if (found_q && in_win) begin
            win0_q[wpos] <= b0;
            win1_q[wpos] <= b1;
         end
      end
   end

`ifdef PIECE_DEC_ERRCNT_EN
   logic [CNT_W-1:0] err_q;

   // --- error counter: consumed match=0 results, saturating ---
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         err_q <= '0;
      end else if (out_valid && out_ready && !match_q && (err_q != '1)) begin
         err_q <= err_q + 1'b1;
      end
   end

   assign err_count = err_q;
`else
   assign err_count = '0;
`endif

endmodule

// File: tb/tb_piece_pattern_decoder.sv
// -----------------------------------------------------------------------------
// tb_piece_pattern_decoder
// Self-checking bench for piece_pattern_decoder: directed patterns, output
// stall, mid-scan reset and randomized patterns against a behavioural model.
// Define PIECE_DEC_ERRCNT_EN to match a DUT built with the error counter.
// -----------------------------------------------------------------------------
module tb_piece_pattern_decoder;

   logic       Clk = 1'b0;
   logic       Reset_n = 1'b1;
   logic       in_valid = 1'b0;
   logic       out_ready = 1'b0;
   logic [9:0] row0 = '0;
   logic [9:0] row1 = '0;
   logic       in_ready;
   logic       out_valid;
   logic [2:0] block;
   logic [3:0] offset;
   logic       match;
   logic [7:0] err_count;

`ifdef PIECE_DEC_ERRCNT_EN
   localparam bit ERRCNT = 1'b1;
`else
   localparam bit ERRCNT = 1'b0;
`endif

   piece_pattern_decoder #(.ROW_W(10), .CNT_W(8)) dut (
      .Clk       (Clk),
      .Reset_n   (Reset_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .row0      (row0),
      .row1      (row1),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .block     (block),
      .offset    (offset),
      .match     (match),
      .err_count (err_count)
   );

   always #5 Clk = ~Clk;

   int         n_cmp = 0;
   int         n_bad = 0;
   logic [7:0] expq[$];
   time        acc_time = 0;
   bit         first_seen = 1'b0;
   bit         pending = 1'b0;
   int         err_m = 0;

   int tab0 [8] = '{4, 2, 8, 6, 12, 12, 0, 14};
   int tab1 [8] = '{14, 14, 14, 12, 6, 12, 15, 14};

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Expected result packed as {match, block[2:0], offset[3:0]}.
   function automatic logic [7:0] model(input logic [9:0] r0, input logic [9:0] r1);
      int occ, off, w0, w1;
      bit ovf;
      logic [7:0] res;
      occ = int'(r0 | r1);
      off = -1;
      for (int c = 0; c < 10; c++)
         if (off < 0 && ((occ >> (9 - c)) & 1) != 0) off = c;
      if (off < 0) return 8'h00;
      w0  = ((int'(r0) << off) >> 6) & 15;
      w1  = ((int'(r1) << off) >> 6) & 15;
      ovf = (((occ << (off + 4)) & 1023) != 0);
      res = {1'b0, 3'b000, 4'(off)};
      if (!ovf)
         for (int i = 0; i < 8; i++)
            if (w0 == tab0[i] && w1 == tab1[i]) res = {1'b1, 3'(i), 4'(off)};
      return res;
   endfunction

   // Per-cycle output checker.
   initial begin
      logic [7:0] e;
      forever begin
         @(negedge Clk);
         if (pending) begin
            pending = 1'b0;
            first_seen = 1'b0;
            if (expq.size() > 0) begin
               e = expq.pop_front();
               if (ERRCNT && !e[7] && err_m < 255) err_m++;
            end
         end
         chk("err_count", 32'(err_count), 32'(err_m));
         if (out_valid) begin
            chk("in_ready_busy", 32'(in_ready), 32'd0);
            if (expq.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_out_valid: got 1 expected 0 at %0t", $time);
            end else begin
               e = expq[0];
               if (!first_seen) begin
                  first_seen = 1'b1;
                  chk("latency", 32'($time - acc_time), 32'd115);
               end
               chk("block", 32'(block), 32'(e[6:4]));
               chk("offset", 32'(offset), 32'(e[3:0]));
               chk("match", 32'(match), 32'(e[7]));
            end
            if (out_ready) pending = 1'b1;
         end
      end
   end

   task automatic send(input logic [9:0] r0, input logic [9:0] r1, input logic [7:0] exp);
      bit ok;
      ok = 1'b0;
      @(posedge Clk);
      #1;
      in_valid = 1'b1;
      row0 = r0;
      row1 = r1;
      for (int k = 0; k < 200; k++) begin
         @(negedge Clk);
         if (in_ready) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         $display("FAIL accept_timeout: got in_ready 0 expected 1 at %0t", $time);
         n_cmp++;
         n_bad++;
         $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
         $fatal(1, "accept timeout");
      end
      @(posedge Clk);
      acc_time = $time;
      expq.push_back(exp);
      #1;
      in_valid = 1'b0;
      row0 = 10'($urandom);
      row1 = 10'($urandom);
   endtask

   task automatic drain(input bit rnd);
      bit ok;
      ok = 1'b0;
      for (int k = 0; k < 400; k++) begin
         if (expq.size() == 0 && !pending) begin
            ok = 1'b1;
            break;
         end
         @(posedge Clk);
         #1;
         out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      if (!ok) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain_timeout: got %0d pending expected 0 at %0t", expq.size(), $time);
         expq.delete();
         pending = 1'b0;
      end
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
      chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
      chk({tag, "_block"}, 32'(block), 32'd0);
      chk({tag, "_offset"}, 32'(offset), 32'd0);
      chk({tag, "_match"}, 32'(match), 32'd0);
      chk({tag, "_err_count"}, 32'(err_count), 32'd0);
   endtask

   initial begin
      logic [9:0] r0, r1;
      int pi, po, sh;
      bit ok;

      #1 Reset_n = 1'b0;
      #2 check_reset_vals("reset");
      #19 Reset_n = 1'b1;

      // Model pinned to hand-computed results.
      chk("model_T", 32'(model(10'b0000100000, 10'b0001110000)), 32'h83);
      chk("model_I", 32'(model(10'b0000000000, 10'b0000001111)), 32'hE6);
      chk("model_O0", 32'(model(10'b1100000000, 10'b1100000000)), 32'hD0);
      chk("model_O8", 32'(model(10'b0000000011, 10'b0000000011)), 32'hD8);
      chk("model_J7", 32'(model(10'b0000000001, 10'b0000000111)), 32'h97);
      chk("model_ovf", 32'(model(10'b1000000001, 10'b0000000000)), 32'h00);
      chk("model_zero", 32'(model(10'b0000000000, 10'b0000000000)), 32'h00);

      // Directed patterns.
      out_ready = 1'b1;
      send(10'b0000100000, 10'b0001110000, 8'h83); drain(1'b0);
      send(10'b0000000000, 10'b0000001111, 8'hE6); drain(1'b0);
      send(10'b1100000000, 10'b1100000000, 8'hD0); drain(1'b0);
      send(10'b0000000011, 10'b0000000011, 8'hD8); drain(1'b0);
      send(10'b0000000001, 10'b0000000111, 8'h97); drain(1'b0);
      send(10'b1000000001, 10'b0000000000, 8'h00); drain(1'b0);
      send(10'b0000000000, 10'b0000000000, 8'h00); drain(1'b0);
      @(negedge Clk);
`ifdef PIECE_DEC_ERRCNT_EN
      chk("errcnt_after_two", 32'(err_count), 32'd2);
`else
      chk("errcnt_tied", 32'(err_count), 32'd0);
`endif

      // Output stall: result held while out_ready is low.
      out_ready = 1'b0;
      send(10'b0000100000, 10'b0001110000, 8'h83);
      ok = 1'b0;
      for (int k = 0; k < 50; k++) begin
         @(negedge Clk);
         if (out_valid) begin
            ok = 1'b1;
            break;
         end
      end
      chk("stall_out_valid_seen", 32'(ok), 32'd1);
      for (int k = 0; k < 5; k++) begin
         @(negedge Clk);
         chk("stall_out_valid", 32'(out_valid), 32'd1);
         chk("stall_in_ready", 32'(in_ready), 32'd0);
      end
      @(posedge Clk);
      #1 out_ready = 1'b1;
      @(posedge Clk);
      #1;
      chk("release_out_valid", 32'(out_valid), 32'd0);
      chk("release_in_ready", 32'(in_ready), 32'd1);
      drain(1'b0);

      // Reset in the middle of a scan.
      send(10'b0000100000, 10'b0001110000, 8'h83);
      repeat (4) @(posedge Clk);
      #1;
      Reset_n = 1'b0;
      expq.delete();
      pending = 1'b0;
      first_seen = 1'b0;
      err_m = 0;
      #1 check_reset_vals("midscan");
      #2 Reset_n = 1'b1;
      send(10'b0000000000, 10'b0000001111, 8'hE6); drain(1'b0);

      // Randomized patterns with random output back-pressure.
      for (int n = 0; n < 150; n++) begin
         if ($urandom_range(0, 1) == 1) begin
            pi = $urandom_range(0, 7);
            sh = $urandom_range(0, 9);
            po = $urandom_range(0, 3);
            r0 = 10'((tab0[pi] << 6) >> sh);
            r1 = 10'((tab1[pi] << 6) >> sh);
            if (po == 0) r0 = r0 | 10'(1 << $urandom_range(0, 9));
         end else begin
            r0 = 10'($urandom) & 10'($urandom);
            r1 = 10'($urandom) & 10'($urandom);
         end
         send(r0, r1, model(r0, r1));
         drain(1'b1);
      end

      repeat (3) @(posedge Clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
